// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory writer: packs 4 bytes MSB-first into a word per write.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the program.
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   state_t            state, state_nxt;
   logic [1:0]        byte_cnt;
   logic [ADDR_W:0]   word_cnt;
   logic [ADDR_W:0]   word_cnt_inc;
   logic [ADDR_W:0]   count;
   logic [23:0]       word_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [31:0]       wr_data_q;
   logic              error_q;
   logic              last_word;
   logic              byte_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]       csum_q;
`endif

   assign word_cnt_inc = word_cnt + (ADDR_W+1)'(1);
   assign last_word    = (word_cnt_inc == count);
   assign byte_last    = in_valid && (byte_cnt == 2'd3);

   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign error   = error_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      wr_en     = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (num_words == '0)          state_nxt = S_DONE;
               else if (num_words <= DEPTH_W) state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            if (byte_last) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            wr_en = 1'b1;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = S_CHECK;
`else
               state_nxt = S_DONE;
`endif
            end else begin
               state_nxt = S_LOAD;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            in_ready = 1'b1;
            if (byte_last) state_nxt = S_DONE;
         end
`endif
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Address/data are captured with the 4th byte so they are valid throughout WRITE
   // and keep their last values afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt  <= '0;
         word_cnt  <= '0;
         count     <= '0;
         word_q    <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         error_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (num_words <= DEPTH_W) begin
                     error_q  <= 1'b0;
                     count    <= num_words;
                     word_cnt <= '0;
                     byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_q   <= '0;
`endif
                  end else begin
                     error_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  word_q   <= {word_q[15:0], in_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     wr_data_q <= {word_q, in_data};
                     wr_addr_q <= word_cnt[ADDR_W-1:0];
                  end
               end
            end
            S_WRITE: begin
               word_cnt <= word_cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_q   <= csum_q ^ wr_data_q;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (in_valid) begin
                  word_q   <= {word_q[15:0], in_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3 && {word_q, in_data} != csum_q) error_q <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
